// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC and FSM states.
package instr_fetch_unit_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 16;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: word-addressed, wraps at the top, a load (redirect) wins over an increment.
// pc_next exposes the value pc takes at the next edge so the fetch FSM can
// present the correct address in the same edge that updates pc.
module pc_register
    import instr_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            incr,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    // Next-PC selection: redirect target first, then sequential increment.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = target;
        end else if (incr) begin
            pc_next = pc + PC_W'(1);
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds each
// fetched instruction until decode takes it, and follows branch redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    pc_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               stall,
    input  logic               halt,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    ifu_state_e      state_reg;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            pc_load;
    logic            pc_incr;
    logic            handoff;

    // Redirects are honoured everywhere except HALTED; the PC only advances on an
    // accepted fetch that is not being overridden by a redirect.
    always_comb begin
        pc_load = redirect_valid && (state_reg != HALTED);
        pc_incr = (state_reg == FETCH) && imem_ack && !redirect_valid;
        handoff = (state_reg == HOLD) && instr_valid && instr_ready && !stall;
    end

    pc_register u_pc_register (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .incr    (pc_incr),
        .target  (pc_target),
        .pc      (pc),
        .pc_next (pc_next)
    );

    // Fetch FSM with registered memory-side and consumer-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg   <= FETCH;
                    imem_req    <= 1'b1;
                    imem_addr   <= pc_next;
                    instr_valid <= 1'b0;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        // Any data returned alongside a redirect belongs to the old path.
                        instr_valid <= 1'b0;
                        imem_addr   <= pc_next;
                        if (imem_ack) begin
                            state_reg <= FETCH;
                            imem_req  <= 1'b1;
                        end else begin
                            state_reg <= FLUSH;
                            imem_req  <= 1'b0;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_next;
                        state_reg   <= FETCH;
                    end else if (handoff) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + CNT_W'(1);
                        if (halt) begin
                            state_reg <= HALTED;
                            halted    <= 1'b1;
                            imem_req  <= 1'b0;
                        end else begin
                            state_reg <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_next;
                        end
                    end
                end
                FLUSH: begin
                    state_reg   <= FETCH;
                    imem_req    <= 1'b1;
                    imem_addr   <= pc_next;
                    instr_valid <= 1'b0;
                end
                HALTED: begin
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    imem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard of fetched words is filled
// when the bench returns memory data and drained at each handoff to decode.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_head;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .pc_target      (pc_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .stall          (stall),
        .halt           (halt),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);
    endtask

    // DUT must be in FETCH at address a; memory answers in the lat-th request cycle.
    task automatic do_fetch(input logic [31:0] a, input int lat);
        for (int i = 0; i < lat; i++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", imem_addr, a);
            if (i == lat - 1) begin
                imem_ack   = 1'b1;
                imem_rdata = rd(a);
                sb.push_back({a, rd(a)});
            end
            tick();
        end
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("fetch_valid", 32'(instr_valid), 32'd1);
        check("fetch_req_drop", 32'(imem_req), 32'd0);
    endtask

    // DUT holds an instruction; compare it with the scoreboard head and let decode take it.
    task automatic handoff_expect();
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            sb_head = sb.pop_front();
            check("sb_instr", instr, sb_head[31:0]);
            check("sb_instr_pc", instr_pc, sb_head[63:32]);
        end
        tick();
        exp_cnt++;
        check("handoff_valid", 32'(instr_valid), 32'd0);
        check("handoff_count", 32'(fetch_count), 32'(exp_cnt));
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        pc_target      = '0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b1;
        stall          = 1'b0;
        halt           = 1'b0;
        tick(); tick(); tick();
        check_reset_state();

        // First post-reset cycle: FSM is in IDLE, a stray ack must be ignored.
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("post_rst_valid", 32'(instr_valid), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, 32'd0);

        // Zero-wait memory, decode always ready: addresses 0,1,2.
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'(k), 1);
            handoff_expect();
        end
        check("count_after_three", 32'(fetch_count), 32'd3);

        do_fetch(32'd3, 1);
        handoff_expect();
        do_fetch(32'd4, 1);
        handoff_expect();

        // Three-cycle memory latency at pc=5, then a 4-cycle stall in HOLD.
        do_fetch(32'd5, 3);
        check("lat3_instr", instr, rd(32'd5));
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, rd(32'd5));
            check("stall_count", 32'(fetch_count), 32'(exp_cnt));
        end
        stall = 1'b0;
        handoff_expect();

        // Redirect without ack in FETCH: one FLUSH cycle with no request.
        check("pre_flush_addr", imem_addr, 32'd6);
        redirect_valid = 1'b1;
        pc_target      = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("flush_req", 32'(imem_req), 32'd0);
        check("flush_valid", 32'(instr_valid), 32'd0);
        tick();
        check("after_flush_req", 32'(imem_req), 32'd1);
        check("after_flush_addr", imem_addr, 32'h40);
        check("flush_count", 32'(fetch_count), 32'(exp_cnt));
        do_fetch(32'h40, 1);
        handoff_expect();

        // Redirect coinciding with ack: data discarded, refetch at the target.
        redirect_valid = 1'b1;
        pc_target      = 32'h80;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hBAD0_BAD0;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        check("coinc_valid", 32'(instr_valid), 32'd0);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h80);
        check("coinc_count", 32'(fetch_count), 32'(exp_cnt));
        do_fetch(32'h80, 2);
        handoff_expect();

        // Redirect in HOLD together with a handoff: the held word is dropped.
        do_fetch(32'h81, 1);
        redirect_valid = 1'b1;
        pc_target      = 32'd7;
        tick();
        redirect_valid = 1'b0;
        void'(sb.pop_front());
        check("hold_redir_valid", 32'(instr_valid), 32'd0);
        check("hold_redir_count", 32'(fetch_count), 32'(exp_cnt));
        check("hold_redir_addr", imem_addr, 32'd7);

        // halt held through FETCH has no effect there; at the handoff of pc=7 it halts.
        halt = 1'b1;
        do_fetch(32'd7, 1);
        handoff_expect();
        check("halted_flag", 32'(halted), 32'd1);
        check("halted_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        pc_target      = 32'h100;
        imem_ack       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halted_hold_req", 32'(imem_req), 32'd0);
            check("halted_hold_flag", 32'(halted), 32'd1);
            check("halted_hold_valid", 32'(instr_valid), 32'd0);
        end

        // Reset wins over redirect and exits HALTED; fetch restarts at 0.
        rst = 1'b1;
        tick();
        check_reset_state();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        halt           = 1'b0;
        exp_cnt        = 0;
        tick();
        check("restart_addr", imem_addr, 32'd0);
        do_fetch(32'd0, 1);
        handoff_expect();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock and one reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The redirect ports SHALL be: redirect_valid input 1 (branch stage requests a PC change this cycle); pc_target input 32 (new PC, the branch stage's computed program counter).
REQ-003 The memory-side ports SHALL be: imem_req output 1 (fetch request); imem_addr output 32 (word address); imem_ack input 1 (read data valid this cycle); imem_rdata input 32 (instruction word).
REQ-004 The consumer-side ports SHALL be: instr output 32 (fetched instruction); instr_pc output 32 (address of instr, fed to the branch stage as its current PC); instr_valid output 1; instr_ready input 1 (decode accepts this cycle).
REQ-005 The control ports SHALL be: stall input 1 (freeze handoff); halt input 1 (stop fetching after the current instruction); halted output 1; fetch_count output 16 (count of instructions handed off).

Function
REQ-006 The FSM SHALL have exactly the states IDLE, FETCH, HOLD, FLUSH and HALTED.
REQ-007 The internal pc SHALL be 32 bits, word-addressed, and SHALL increment by 1 with wrap from 0xFFFFFFFF to 0.
REQ-008 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-009 In FETCH, imem_req SHALL be 1, imem_addr SHALL equal pc, and both SHALL stay stable until imem_ack.
REQ-010 On imem_ack in FETCH, the next edge SHALL load: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1, state HOLD.
REQ-011 imem_ack SHALL be accepted in the same cycle that imem_req first rises, giving a fetch latency of 1 cycle minimum.
REQ-012 In HOLD, instr, instr_pc and instr_valid SHALL stay stable until instr_ready=1 and stall=0 (handoff).
REQ-013 On handoff, the next edge SHALL set instr_valid<=0 and fetch_count<=fetch_count+1 (16-bit wrap), and SHALL enter HALTED if halt=1, else FETCH.
REQ-014 stall=1 SHALL block handoff only; it SHALL NOT block an outstanding fetch or a redirect.
REQ-015 When redirect_valid=1 in IDLE, FETCH, HOLD or FLUSH, the next edge SHALL set pc<=pc_target and instr_valid<=0, with no handoff and no count increment.
REQ-016 A redirect in FETCH without imem_ack SHALL move the FSM to FLUSH, with imem_req=0 for exactly one cycle, then FETCH from pc_target.
REQ-017 A redirect coinciding with imem_ack SHALL discard the ack data and move the FSM to FETCH directly.
REQ-018 A redirect in HOLD, with or without a simultaneous handoff, SHALL take priority: the held instruction is dropped, the count is not incremented, and the FSM goes to FETCH.
REQ-019 In HALTED, imem_req SHALL be 0, halted SHALL be 1, redirect_valid SHALL be ignored, and only rst SHALL exit the state.
REQ-020 halt asserted outside HOLD SHALL have no effect.
REQ-021 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL set: pc=RESET_PC (0), state=IDLE, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
REQ-023 Reset SHALL have priority over every input, including mid-fetch and HALTED.
REQ-024 A pending imem_ack in the first post-reset cycle SHALL be ignored, because the FSM is in IDLE.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, RESET_PC, PC_W=32, INSTR_W=32 and CNT_W=16.
REQ-026 The block SHALL contain one sub-module, pc_register, holding pc with load and increment enables and redirect-over-increment priority; the FSM and output registers SHALL stay in instr_fetch_unit.

Verification
REQ-027 The bench SHALL check: reset, then zero-wait memory with instr_ready=1 -> imem_addr 0,1,2 on successive fetches, instr_pc matching, fetch_count=3 after three handoffs.
REQ-028 The bench SHALL check: 3-cycle ack latency at pc=5 -> imem_req and imem_addr=5 held 3 cycles, then instr_valid=1 with instr=rdata.
REQ-029 The bench SHALL check: HOLD with stall=1 for 4 cycles, instr_ready=1 -> no handoff, instr stable, count unchanged; stall=0 -> handoff, count +1.
REQ-030 The bench SHALL check: redirect_valid=1 with pc_target=0x40 and no ack in FETCH -> one FLUSH cycle with imem_req=0, then imem_addr=0x40.
REQ-031 The bench SHALL check: redirect_valid coinciding with imem_ack -> data discarded, instr_valid stays 0, next fetch at pc_target.
REQ-032 The bench SHALL check: halt=1 at the handoff of pc=7 -> halted=1, imem_req=0 indefinitely, redirect ignored; rst=1 -> fetch restarts at 0.
